// File: rtl/sig_control_timed_pkg.sv
// Shared light and state encodings for the timed highway/country signal controller.
package sig_control_timed_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } light_t;

    // S2 and S5 are both all-red clearances; S2 leads into the country phase, S5 back to the highway
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

endpackage

// File: rtl/sig_control_timed_phase_timer.sv
// Saturating phase timer: zero in the first cycle of a phase, then counts up once per cycle.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             restart,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sig_control_timed.sv
// Highway/country intersection controller with timed phases, pedestrian walk and emergency override.
module sig_control_timed
    import sig_control_timed_pkg::*;
#(
    parameter int Y_CYCLES    = 3,
    parameter int AR_CYCLES   = 2,
    parameter int MIN_HG      = 8,
    parameter int MAX_CG      = 10,
    parameter int WALK_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic       ped_pending
);

    if (Y_CYCLES < 1 || AR_CYCLES < 1 || MIN_HG < 1 || MAX_CG < 1 || WALK_CYCLES < 1 ||
        CNT_W < 1 || WALK_CYCLES > MAX_CG || MAX_CG >= (1 << CNT_W) ||
        MIN_HG >= (1 << CNT_W) || Y_CYCLES >= (1 << CNT_W)) begin : g_param_err
        $error("sig_control_timed: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] HG_LAST   = CNT_W'(MIN_HG - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(Y_CYCLES - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CG_LAST   = CNT_W'(MAX_CG - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LEN  = CNT_W'(WALK_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             walk_phase;
    logic             serve;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .clear   (clear),
        .restart (state_nxt != state),
        .cnt     (cnt)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S0: if ((x || ped_pending) && !emerg && cnt >= HG_LAST) state_nxt = S1;
            S1: if (cnt == Y_LAST) state_nxt = S2;
            S2: if (cnt == AR_LAST) state_nxt = emerg ? S5 : S3;
            S3: if (emerg || cnt == CG_LAST || (!x && !walk_phase) ||
                    (!x && walk_phase && cnt >= WALK_LAST)) state_nxt = S4;
            S4: if (cnt == Y_LAST) state_nxt = S5;
            S5: if (cnt == AR_LAST) state_nxt = S0;
            default: state_nxt = S0;
        endcase
    end

    assign serve = (state == S2) && (state_nxt == S3);

    // A request arriving on the very edge into S3 is folded into this walk; later ones wait a full cycle
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            ped_pending <= 1'b0;
            walk_phase  <= 1'b0;
        end else if (serve) begin
            walk_phase  <= ped_pending || ped_req;
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb begin
        hwy   = RED;
        cntry = RED;
        walk  = 1'b0;
        unique case (state)
            S0: hwy = GREEN;
            S1: hwy = YELLOW;
            S3: begin
                cntry = GREEN;
                walk  = walk_phase && (cnt < WALK_LEN);
            end
            S4: cntry = YELLOW;
            default: ;
        endcase
    end

endmodule
